// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch front end for the 16-bit CPU. Drives PC into the
//   combinational InstructionMemory and captures the returned word into an
//   instruction register (IR). IR goes to decode over a valid/ready handshake.
//   Also handles stalls, branch/jump redirects and HALT detection.
//
// Ports
//   Clock          in   1   rising-edge clock
//   Reset_n        in   1   asynchronous active-low reset
//   PC             out  16  fetch address to InstructionMemory (registered)
//   Instruction    in   16  memory word for PC (combinational return)
//   IR             out  16  registered instruction to decode
//   IRValid        out  1   IR holds an undelivered instruction
//   IRReady        in   1   decode accepts IR this cycle
//   Redirect       in   1   branch/jump taken (single-cycle pulse)
//   RedirectTarget in   16  new PC when Redirect is high
//   Halted         out  1   sequencer is in the HALTED state
//   FetchCount     out  16  number of completed IR handshakes (wraps)
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'd2,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic [15:0] PC,
  input  logic [15:0] Instruction,
  output logic [15:0] IR,
  output logic        IRValid,
  input  logic        IRReady,
  input  logic        Redirect,
  input  logic [15:0] RedirectTarget,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        halted_q, halted_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic handshake;
  logic slot_free;
  logic is_halt;

  // The IR slot can take a new word when it is empty or is being drained in
  // this same cycle. This allows back-to-back transfers at full throughput.
  assign handshake = ir_valid_q & IRReady;
  assign slot_free = ~ir_valid_q | IRReady;
  assign is_halt   = (Instruction[15:12] == HALT_OPCODE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    // A handshake completes whatever else happens, including a redirect
    // that then discards the IR contents.
    if (handshake) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    case (state_q)
      ST_BOOT: begin
        // Redirect is ignored here. The idle cycle lets memory settle on RESET_PC.
        state_d = ST_FETCH;
      end
      default: begin
        if (Redirect) begin
          pc_d       = RedirectTarget;
          ir_valid_d = 1'b0;
          halted_d   = 1'b0;
          state_d    = ST_FETCH;
        end else if ((state_q == ST_FETCH) && slot_free) begin
          ir_d       = Instruction;
          ir_valid_d = 1'b1;
          if (is_halt) begin
            // The HALT word is delivered like any other word. PC stays on its address.
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end else if (handshake) begin
          ir_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      ir_q          <= 16'h0000;
      ir_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign PC         = pc_q;
  assign IR         = ir_q;
  assign IRValid    = ir_valid_q;
  assign Halted     = halted_q;
  assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        Clock;
  logic        Reset_n;
  logic [15:0] PC;
  logic [15:0] Instruction;
  logic [15:0] IR;
  logic        IRValid;
  logic        IRReady;
  logic        Redirect;
  logic [15:0] RedirectTarget;
  logic        Halted;
  logic [15:0] FetchCount;

  int checks = 0;
  int errors = 0;

  // Words the bench expects decode to receive, in order.
  logic [15:0] exp_q[$];

  fetch_sequencer dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .PC             (PC),
    .Instruction    (Instruction),
    .IR             (IR),
    .IRValid        (IRValid),
    .IRReady        (IRReady),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Halted         (Halted),
    .FetchCount     (FetchCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory model: the word at addr k is 16'h1000+k. Address 0x0010 holds a HALT.
  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    logic [15:0] w;
    if (addr == 16'h0010) w = 16'hF000;
    else                  w = 16'h1000 + addr;
    return w;
  endfunction

  always_comb Instruction = mem_word(PC);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Scoreboard: a handshake visible at the negedge completes at the next posedge.
  always @(negedge Clock) begin
    if (Reset_n && IRValid && IRReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver: unexpected handshake IR=%h, expected none", IR);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("deliver", IR, e);
        $display("deliver IR=%h expected=%h FetchCount=%0d", IR, e, FetchCount);
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] tgt;
    logic        push;
    logic [15:0] push_val;
    logic [15:0] e_pc;
    logic [15:0] e_ir;
    logic        e_valid;
    logic [15:0] e_fc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // rdy redir tgt push push_val | e_pc e_ir e_valid e_fc   (IR only checked when valid)
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0}; // BOOT
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0002, 16'h1000, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1000, 16'h0004, 16'h1002, 1'b1, 16'd1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0004, 16'h1002, 1'b1, 16'd1}; // stall
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0004, 16'h1002, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0004, 16'h1002, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0004, 16'h1002, 1'b1, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1002, 16'h0006, 16'h1004, 1'b1, 16'd2}; // resume
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0006, 16'h1004, 1'b1, 16'd2};
    tbl[9]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0040, 16'h0000, 1'b0, 16'd2}; // redirect in stall
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0042, 16'h1040, 1'b1, 16'd2};
    tbl[11] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h1040, 16'h0008, 16'h0000, 1'b0, 16'd3}; // redirect + handshake
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h000A, 16'h1008, 1'b1, 16'd3};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1008, 16'h000C, 16'h100A, 1'b1, 16'd4};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h000C, 16'h100A, 1'b1, 16'd4};

    Reset_n        = 1'b0;
    IRReady        = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = 16'h0000;
    step();
    step();
    chk("reset_pc", PC, 16'h0000);
    chk("reset_ir", IR, 16'h0000);
    chk("reset_valid", {15'd0, IRValid}, 16'd0);
    chk("reset_halted", {15'd0, Halted}, 16'd0);
    chk("reset_fc", FetchCount, 16'd0);
    $display("reset PC=%h IR=%h IRValid=%b FetchCount=%0d", PC, IR, IRValid, FetchCount);

    Reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      IRReady        = tbl[i].rdy;
      Redirect       = tbl[i].redir;
      RedirectTarget = tbl[i].tgt;
      if (tbl[i].push) exp_q.push_back(tbl[i].push_val);
      step();
      chk("vec_pc", PC, tbl[i].e_pc);
      chk("vec_valid", {15'd0, IRValid}, {15'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) chk("vec_ir", IR, tbl[i].e_ir);
      chk("vec_fc", FetchCount, tbl[i].e_fc);
      chk("vec_halted", {15'd0, Halted}, 16'd0);
      $display("vec %0d PC=%h IR=%h IRValid=%b FetchCount=%0d", i, PC, IR, IRValid, FetchCount);
    end
    Redirect = 1'b0;

    // HALT: stream up to address 0x0010, which holds 16'hF000.
    IRReady = 1'b1;
    exp_q.push_back(16'h100A);
    step();
    chk("pre_halt_pc", PC, 16'h000E);
    exp_q.push_back(16'h100C);
    step();
    chk("pre_halt_pc2", PC, 16'h0010);
    exp_q.push_back(16'h100E);
    step();
    chk("halt_ir", IR, 16'hF000);
    chk("halt_flag", {15'd0, Halted}, 16'd1);
    chk("halt_pc", PC, 16'h0010);
    chk("halt_fc", FetchCount, 16'd7);
    $display("halt IR=%h Halted=%b PC=%h FetchCount=%0d", IR, Halted, PC, FetchCount);
    exp_q.push_back(16'hF000);
    step();
    chk("halt_deliver_fc", FetchCount, 16'd8);
    chk("halt_deliver_valid", {15'd0, IRValid}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halted_pc_hold", PC, 16'h0010);
      chk("halted_fc_hold", FetchCount, 16'd8);
      chk("halted_stays", {15'd0, Halted}, 16'd1);
    end
    $display("halted hold PC=%h FetchCount=%0d", PC, FetchCount);
    Redirect       = 1'b1;
    RedirectTarget = 16'h0000;
    step();
    chk("unhalt_flag", {15'd0, Halted}, 16'd0);
    chk("unhalt_pc", PC, 16'h0000);
    chk("unhalt_valid", {15'd0, IRValid}, 16'd0);
    Redirect = 1'b0;
    IRReady  = 1'b0;
    step();
    chk("unhalt_ir", IR, 16'h1000);
    chk("unhalt_pc2", PC, 16'h0002);
    $display("unhalt IR=%h PC=%h Halted=%b", IR, PC, Halted);

    // Wrap: redirect to 0xFFFE, next PC wraps to 0x0000.
    Redirect       = 1'b1;
    RedirectTarget = 16'hFFFE;
    step();
    chk("wrap_redirect_pc", PC, 16'hFFFE);
    Redirect = 1'b0;
    step();
    chk("wrap_pc", PC, 16'h0000);
    chk("wrap_ir", IR, 16'h0FFE);
    IRReady = 1'b1;
    exp_q.push_back(16'h0FFE);
    step();
    chk("wrap_next_ir", IR, 16'h1000);
    chk("wrap_next_pc", PC, 16'h0002);
    chk("wrap_fc", FetchCount, 16'd9);
    $display("wrap IR=%h PC=%h FetchCount=%0d", IR, PC, FetchCount);

    // Asynchronous reset between edges, with IRValid still high.
    IRReady = 1'b0;
    #2;
    chk("pre_areset_valid", {15'd0, IRValid}, 16'd1);
    Reset_n = 1'b0;
    #1;
    chk("areset_pc", PC, 16'h0000);
    chk("areset_valid", {15'd0, IRValid}, 16'd0);
    chk("areset_fc", FetchCount, 16'd0);
    chk("areset_halted", {15'd0, Halted}, 16'd0);
    chk("areset_ir", IR, 16'h0000);
    $display("async reset PC=%h IRValid=%b FetchCount=%0d", PC, IRValid, FetchCount);
    step();

    // Redirect during BOOT is ignored.
    Reset_n        = 1'b1;
    Redirect       = 1'b1;
    RedirectTarget = 16'h0080;
    step();
    chk("boot_redirect_pc", PC, 16'h0000);
    chk("boot_redirect_valid", {15'd0, IRValid}, 16'd0);
    Redirect = 1'b0;
    step();
    chk("after_boot_pc", PC, 16'h0002);
    chk("after_boot_ir", IR, 16'h1000);
    $display("boot redirect ignored PC=%h IR=%h", PC, IR);

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
